// File: rtl/vending_transaction_controller.sv
// Vending machine sequencing controller: owns the balance register, the
// coin-return timeout, dispense decisions and one-coin-per-cycle change payout.
module vending_transaction_controller #(
  parameter int kNumCoins = 3,
  parameter int kNumItems = 4,
  parameter int kWaitTime = 100
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [kNumCoins-1:0] i_input_coin,
  input  logic [kNumItems-1:0] i_select_item,
  input  logic                 i_trigger_return,
  output logic [kNumItems-1:0] o_available_item,
  output logic [kNumItems-1:0] o_output_item,
  output logic [kNumCoins-1:0] o_return_coin,
  output logic [31:0]          o_current_total,
  output logic [31:0]          o_wait_time,
  output logic [1:0]           o_state_dbg
);

  // Pulse inputs carry no handshake: a set bit in any cycle is one event,
  // consumed or dropped in that same cycle according to the current state.

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_RETURN = 2'd2
  } state_e;

  localparam logic [31:0] kWaitLoad = 32'(kWaitTime);

  function automatic logic [31:0] coin_value(input int idx);
    case (idx)
      0:       coin_value = 32'd100;
      1:       coin_value = 32'd500;
      2:       coin_value = 32'd1000;
      default: coin_value = 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] item_price(input int idx);
    case (idx)
      0:       item_price = 32'd400;
      1:       item_price = 32'd500;
      2:       item_price = 32'd1000;
      3:       item_price = 32'd2000;
      default: item_price = 32'd0;
    endcase
  endfunction

  state_e                 state_q, state_d;
  logic [31:0]            total_q, total_d;
  logic [31:0]            wait_q, wait_d;
  logic [kNumItems-1:0]   out_item_q, out_item_d;
  logic [kNumCoins-1:0]   ret_coin_q, ret_coin_d;

  logic [31:0]            coin_sum;
  logic                   sel_found;
  logic [kNumItems-1:0]   sel_oh;
  logic [31:0]            sel_price;
  logic                   sel_valid;
  logic [kNumCoins-1:0]   ret_oh;
  logic [31:0]            ret_val;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      total_q    <= '0;
      wait_q     <= '0;
      out_item_q <= '0;
      ret_coin_q <= '0;
    end else begin
      state_q    <= state_d;
      total_q    <= total_d;
      wait_q     <= wait_d;
      out_item_q <= out_item_d;
      ret_coin_q <= ret_coin_d;
    end
  end

  // Datapath helpers: this cycle's coin sum, lowest requested item, and the
  // largest coin that fits in the registered balance (coin values ascend).
  always_comb begin
    coin_sum  = '0;
    sel_found = 1'b0;
    sel_oh    = '0;
    sel_price = '0;
    ret_oh    = '0;
    ret_val   = '0;
    for (int i = 0; i < kNumCoins; i++) begin
      if (i_input_coin[i]) coin_sum = coin_sum + coin_value(i);
    end
    for (int i = 0; i < kNumItems; i++) begin
      if (i_select_item[i] && !sel_found) begin
        sel_found = 1'b1;
        sel_oh[i] = 1'b1;
        sel_price = item_price(i);
      end
    end
    for (int i = 0; i < kNumCoins; i++) begin
      if (coin_value(i) != 32'd0 && coin_value(i) <= total_q) begin
        ret_oh    = '0;
        ret_oh[i] = 1'b1;
        ret_val   = coin_value(i);
      end
    end
    sel_valid = sel_found && (sel_price <= total_q);
  end

  always_comb begin
    for (int i = 0; i < kNumItems; i++) begin
      o_available_item[i] = (state_q != S_RETURN) && (total_q >= item_price(i));
    end
  end

  always_comb begin
    state_d    = state_q;
    total_d    = total_q;
    wait_d     = wait_q;
    out_item_d = '0;
    ret_coin_d = '0;
    case (state_q)
      S_IDLE: begin
        if (coin_sum != 32'd0) begin
          total_d = coin_sum;
          wait_d  = kWaitLoad;
          state_d = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        if (i_trigger_return) begin
          wait_d  = '0;
          state_d = S_RETURN;
        end else begin
          // The select is judged against the balance before this cycle's coins.
          if (sel_valid) begin
            out_item_d = sel_oh;
            total_d    = total_q + coin_sum - sel_price;
          end else begin
            total_d = total_q + coin_sum;
          end
          if (coin_sum != 32'd0 || sel_valid) begin
            wait_d = kWaitLoad;
          end else if (wait_q == 32'd0) begin
            state_d = S_RETURN;
          end else begin
            wait_d = wait_q - 32'd1;
          end
          if (sel_valid && total_d == 32'd0) begin
            wait_d  = '0;
            state_d = S_IDLE;
          end
        end
      end
      S_RETURN: begin
        wait_d = '0;
        if (total_q == 32'd0 || ret_val == 32'd0) begin
          total_d = '0;
          state_d = S_IDLE;
        end else begin
          ret_coin_d = ret_oh;
          total_d    = total_q - ret_val;
          if (total_d == 32'd0) state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        total_d = '0;
        wait_d  = '0;
      end
    endcase
  end

  assign o_output_item   = out_item_q;
  assign o_return_coin   = ret_coin_q;
  assign o_current_total = total_q;
  assign o_wait_time     = wait_q;
  assign o_state_dbg     = state_q;

endmodule

// File: tb/tb_vending_transaction_controller.sv
// Directed bench for vending_transaction_controller with a short timeout
// (kWaitTime = 5); change payout is checked against an expected coin queue.
module tb_vending_transaction_controller;

  localparam int kNumCoins = 3;
  localparam int kNumItems = 4;
  localparam int kWaitTime = 5;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_RETURN = 2'd2;

  logic                 clk;
  logic                 reset;
  logic [kNumCoins-1:0] i_input_coin;
  logic [kNumItems-1:0] i_select_item;
  logic                 i_trigger_return;
  logic [kNumItems-1:0] o_available_item;
  logic [kNumItems-1:0] o_output_item;
  logic [kNumCoins-1:0] o_return_coin;
  logic [31:0]          o_current_total;
  logic [31:0]          o_wait_time;
  logic [1:0]           o_state_dbg;

  int n_compared;
  int n_mismatched;
  logic [kNumCoins-1:0] exp_q[$];

  vending_transaction_controller #(
    .kNumCoins(kNumCoins),
    .kNumItems(kNumItems),
    .kWaitTime(kWaitTime)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .i_input_coin     (i_input_coin),
    .i_select_item    (i_select_item),
    .i_trigger_return (i_trigger_return),
    .o_available_item (o_available_item),
    .o_output_item    (o_output_item),
    .o_return_coin    (o_return_coin),
    .o_current_total  (o_current_total),
    .o_wait_time      (o_wait_time),
    .o_state_dbg      (o_state_dbg)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] observed,
                          input logic [31:0] expected);
    n_compared++;
    if (observed !== expected) begin
      n_mismatched++;
      $display("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)",
               tag, observed, observed, expected, expected);
    end
  endtask

  task automatic drive(input logic [2:0] coin, input logic [3:0] sel,
                       input logic trig);
    i_input_coin     = coin;
    i_select_item    = sel;
    i_trigger_return = trig;
  endtask

  // Scoreboard for change payout: every pulse pops exp_q; pulses must be
  // consecutive and the machine must end in IDLE within the cycle budget.
  task automatic drain_return(input string tag, input int exp_pulses);
    int pulses;
    bit done;
    pulses = 0;
    done   = 1'b0;
    for (int c = 0; c < 10 && !done; c++) begin
      tick();
      if (o_return_coin != '0) begin
        pulses++;
        check_eq({tag, "_dispense_clear"}, 32'(o_output_item), 32'd0);
        if (exp_q.size() > 0) check_eq({tag, "_coin"}, 32'(o_return_coin), 32'(exp_q.pop_front()));
        else check_eq({tag, "_extra_coin"}, 32'(o_return_coin), 32'd0);
      end else if (o_state_dbg == ST_RETURN) begin
        check_eq({tag, "_gap"}, 32'(pulses), 32'(exp_pulses));
      end
      if (o_state_dbg == ST_IDLE) done = 1'b1;
    end
    check_eq({tag, "_done_idle"}, 32'(o_state_dbg), 32'(ST_IDLE));
    check_eq({tag, "_pulses"}, 32'(pulses), 32'(exp_pulses));
    check_eq({tag, "_left"}, 32'(exp_q.size()), 32'd0);
    check_eq({tag, "_total"}, o_current_total, 32'd0);
    exp_q.delete();
    tick();
    check_eq({tag, "_after"}, 32'(o_return_coin), 32'd0);
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;

    // 1. Reset held two cycles with coins applied
    reset = 1'b1;
    drive(3'b111, 4'b0000, 1'b0);
    tick();
    tick();
    check_eq("rst_total", o_current_total, 32'd0);
    check_eq("rst_state", 32'(o_state_dbg), 32'(ST_IDLE));
    check_eq("rst_wait", o_wait_time, 32'd0);
    check_eq("rst_item", 32'(o_output_item), 32'd0);
    check_eq("rst_coin", 32'(o_return_coin), 32'd0);
    check_eq("rst_avail", 32'(o_available_item), 32'd0);
    reset = 1'b0;
    drive(3'b000, 4'b0000, 1'b0);
    tick();
    check_eq("idle_hold_total", o_current_total, 32'd0);

    // 2. Insert 1000, buy item 0 (400), return 600 as 500 + 100
    drive(3'b100, 4'b0000, 1'b0);
    tick();
    check_eq("t2_total_1000", o_current_total, 32'd1000);
    check_eq("t2_state_active", 32'(o_state_dbg), 32'(ST_ACTIVE));
    check_eq("t2_wait_load", o_wait_time, 32'd5);
    check_eq("t2_avail", 32'(o_available_item), 32'b0111);
    drive(3'b000, 4'b0001, 1'b0);
    tick();
    check_eq("t2_dispense", 32'(o_output_item), 32'b0001);
    check_eq("t2_total_600", o_current_total, 32'd600);
    check_eq("t2_wait_reload", o_wait_time, 32'd5);
    drive(3'b000, 4'b0000, 1'b0);
    tick();
    check_eq("t2_pulse_one_cycle", 32'(o_output_item), 32'd0);
    check_eq("t2_wait_dec", o_wait_time, 32'd4);
    drive(3'b000, 4'b0000, 1'b1);
    tick();
    drive(3'b000, 4'b0000, 1'b0);
    check_eq("t2_state_return", 32'(o_state_dbg), 32'(ST_RETURN));
    check_eq("t2_return_wait", o_wait_time, 32'd0);
    exp_q.push_back(3'b010);
    exp_q.push_back(3'b001);
    drain_return("t2_ret", 2);

    // 3. Insufficient funds: 500 cannot buy item 3
    drive(3'b010, 4'b0000, 1'b0);
    tick();
    drive(3'b000, 4'b1000, 1'b0);
    tick();
    check_eq("t3_no_dispense", 32'(o_output_item), 32'd0);
    check_eq("t3_total_500", o_current_total, 32'd500);
    check_eq("t3_avail", 32'(o_available_item), 32'b0011);
    drive(3'b000, 4'b0000, 1'b1);
    tick();
    drive(3'b000, 4'b0000, 1'b0);
    check_eq("t3_avail_in_return", 32'(o_available_item), 32'd0);
    exp_q.push_back(3'b010);
    drain_return("t3_ret", 1);

    // 4. Coin and select in the same cycle: select sees the old 400
    for (int k = 0; k < 4; k++) begin
      drive(3'b001, 4'b0000, 1'b0);
      tick();
    end
    check_eq("t4_total_400", o_current_total, 32'd400);
    drive(3'b001, 4'b0010, 1'b0);
    tick();
    check_eq("t4_no_dispense", 32'(o_output_item), 32'd0);
    check_eq("t4_total_500", o_current_total, 32'd500);
    drive(3'b000, 4'b0010, 1'b0);
    tick();
    drive(3'b000, 4'b0000, 1'b0);
    check_eq("t4_dispense", 32'(o_output_item), 32'b0010);
    check_eq("t4_total_0", o_current_total, 32'd0);
    check_eq("t4_state_idle", 32'(o_state_dbg), 32'(ST_IDLE));
    check_eq("t4_wait_0", o_wait_time, 32'd0);
    tick();
    check_eq("t4_no_return", 32'(o_return_coin), 32'd0);

    // 5. Timeout: wait counts 5..0 in ACTIVE, RETURN on the next edge
    drive(3'b001, 4'b0000, 1'b0);
    tick();
    drive(3'b000, 4'b0000, 1'b0);
    check_eq("t5_wait_load", o_wait_time, 32'd5);
    for (int k = 0; k < kWaitTime; k++) tick();
    check_eq("t5_wait_zero", o_wait_time, 32'd0);
    check_eq("t5_still_active", 32'(o_state_dbg), 32'(ST_ACTIVE));
    tick();
    check_eq("t5_timeout_return", 32'(o_state_dbg), 32'(ST_RETURN));
    check_eq("t5_total_kept", o_current_total, 32'd100);
    exp_q.push_back(3'b001);
    drain_return("t5_ret", 1);

    // 6. Reset in the middle of a 3000 payout
    for (int k = 0; k < 3; k++) begin
      drive(3'b100, 4'b0000, 1'b0);
      tick();
    end
    check_eq("t6_total_3000", o_current_total, 32'd3000);
    drive(3'b000, 4'b0000, 1'b1);
    tick();
    drive(3'b000, 4'b0000, 1'b0);
    tick();
    check_eq("t6_first_coin", 32'(o_return_coin), 32'b100);
    check_eq("t6_total_2000", o_current_total, 32'd2000);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("t6_rst_total", o_current_total, 32'd0);
    check_eq("t6_rst_state", 32'(o_state_dbg), 32'(ST_IDLE));
    check_eq("t6_rst_coin", 32'(o_return_coin), 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check_eq("t6_no_more_coins", 32'(o_return_coin), 32'd0);
    end
    check_eq("t6_final_total", o_current_total, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
